// File: rtl/spi_pkg.sv
// Shared SPI controller types: FSM state encoding, mode-0 constants and the legacy
// transaction codes still used by older peripheral init sequencers.
package spi_pkg;

    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TXING    = 3'd1,
        S_RXING    = 3'd2,
        S_DONE     = 3'd3,
        S_WAIT_OUT = 3'd4,
        S_ERROR    = 3'd5
    } spi_ctrl_state_t;

    typedef enum logic [2:0] {
        WRITE_8         = 3'd0,
        WRITE_16        = 3'd1,
        WRITE_8_READ_8  = 3'd2,
        WRITE_8_READ_16 = 3'd3,
        WRITE_8_READ_24 = 3'd4
    } spi_transaction_t;

    function automatic int unsigned tx_len_of(input spi_transaction_t t);
        case (t)
            WRITE_16: return 16;
            default:  return 8;
        endcase
    endfunction

    function automatic int unsigned rx_len_of(input spi_transaction_t t);
        case (t)
            WRITE_8_READ_8:  return 8;
            WRITE_8_READ_16: return 16;
            WRITE_8_READ_24: return 24;
            default:         return 0;
        endcase
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Serial clock generator: toggles sclk every CLK_DIV enabled cycles and flags the
// cycle before each leading (rise) and trailing (fall) edge so the FSM acts on the same edge.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             sclk_q;
    logic             tick;

    assign tick = en && (cnt_q == CNT_W'(CLK_DIV - 1));
    assign rise = tick && (sclk_q == SPI_CPOL);
    assign fall = tick && (sclk_q != SPI_CPOL);
    assign sclk = sclk_q;

    // Disabling restarts the count so every transaction begins with a full setup half-period.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt_q  <= '0;
            sclk_q <= SPI_CPOL;
        end else if (tick) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_controller_param.sv
// Parametrised mode-0 SPI main: optional write phase then optional read phase under one csb window.
// Build option SPI_CTRL_LOOPBACK_EN adds a loopback input that routes mosi back into the read path.
module spi_controller_param
    import spi_pkg::*;
#(
    parameter int unsigned TX_W    = 24,
    parameter int unsigned RX_W    = 24,
    parameter int unsigned CLK_DIV = 1,
    parameter int unsigned LEN_W   = $clog2(((TX_W > RX_W) ? TX_W : RX_W) + 1)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             sclk,
    output logic             csb,
    output logic             mosi,
    input  logic             miso,
`ifdef SPI_CTRL_LOOPBACK_EN
    input  logic             loopback,
`endif
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [TX_W-1:0]  i_data,
    input  logic [LEN_W-1:0] i_tx_len,
    input  logic [LEN_W-1:0] i_rx_len,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [RX_W-1:0]  o_data,
    output logic [LEN_W-1:0] bit_counter
);

    spi_ctrl_state_t  state_q, state_d;
    logic [TX_W-1:0]  tx_data_q;
    logic [LEN_W-1:0] rx_len_q;
    logic [LEN_W-1:0] bit_cnt_q;
    logic [LEN_W-1:0] tx_len_c, rx_len_c;
    logic [RX_W-1:0]  rx_sr_q;
    logic [RX_W-1:0]  o_data_q;
    logic             accept;
    logic             sclk_en;
    logic             sclk_rise, sclk_fall;
    logic             phase_end;
    logic             rx_mosi;
    logic             rx_bit;

    assign tx_len_c  = (i_tx_len > LEN_W'(TX_W)) ? LEN_W'(TX_W) : i_tx_len;
    assign rx_len_c  = (i_rx_len > LEN_W'(RX_W)) ? LEN_W'(RX_W) : i_rx_len;
    assign accept    = i_valid && i_ready;
    assign sclk_en   = (state_q == S_TXING) || (state_q == S_RXING);
    assign phase_end = sclk_fall && (bit_cnt_q == '0);

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (sclk_en),
        .sclk (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

`ifdef SPI_CTRL_LOOPBACK_EN
    logic [LEN_W-1:0] tx_len_q;
    logic [LEN_W-1:0] lb_idx_q;

    // Loopback index walks the write word MSB-first and wraps, continuing through the read phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_len_q <= '0;
            lb_idx_q <= '0;
        end else if (accept) begin
            tx_len_q <= tx_len_c;
            lb_idx_q <= (tx_len_c != '0) ? tx_len_c - 1'b1 : '0;
        end else if (sclk_fall) begin
            if (lb_idx_q != '0) begin
                lb_idx_q <= lb_idx_q - 1'b1;
            end else begin
                lb_idx_q <= (tx_len_q != '0) ? tx_len_q - 1'b1 : '0;
            end
        end
    end

    assign rx_mosi = loopback && tx_data_q[lb_idx_q];
    assign rx_bit  = loopback ? rx_mosi : miso;
`else
    assign rx_mosi = 1'b0;
    assign rx_bit  = miso;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (tx_len_c != '0) begin
                        state_d = S_TXING;
                    end else if (rx_len_c != '0) begin
                        state_d = S_RXING;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_TXING: begin
                if (phase_end) begin
                    state_d = (rx_len_q != '0) ? S_RXING : S_DONE;
                end
            end
            S_RXING: begin
                if (phase_end) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:     state_d = (rx_len_q != '0) ? S_WAIT_OUT : S_IDLE;
            S_WAIT_OUT: state_d = o_ready ? S_IDLE : S_WAIT_OUT;
            S_ERROR:    state_d = S_ERROR;
            default:    state_d = S_ERROR;
        endcase
    end

    always_comb begin
        i_ready = 1'b0;
        o_valid = 1'b0;
        csb     = 1'b1;
        mosi    = 1'b0;
        case (state_q)
            S_IDLE:     i_ready = 1'b1;
            S_TXING: begin
                csb  = 1'b0;
                mosi = tx_data_q[bit_cnt_q];
            end
            S_RXING: begin
                csb  = 1'b0;
                mosi = rx_mosi;
            end
            S_WAIT_OUT: o_valid = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_q <= '0;
            rx_len_q  <= '0;
            bit_cnt_q <= '0;
            rx_sr_q   <= '0;
            o_data_q  <= '0;
        end else begin
            if (accept) begin
                tx_data_q <= i_data;
                rx_len_q  <= rx_len_c;
                rx_sr_q   <= '0;
                if (tx_len_c != '0) begin
                    bit_cnt_q <= tx_len_c - 1'b1;
                end else if (rx_len_c != '0) begin
                    bit_cnt_q <= rx_len_c - 1'b1;
                end else begin
                    bit_cnt_q <= '0;
                end
            end
            if ((state_q == S_RXING) && sclk_rise) begin
                rx_sr_q <= {rx_sr_q[RX_W-2:0], rx_bit};
            end
            // The last write bit hands straight over to the read count: no gap, no extra sclk.
            if (sclk_fall) begin
                if (bit_cnt_q != '0) begin
                    bit_cnt_q <= bit_cnt_q - 1'b1;
                end else if ((state_q == S_TXING) && (rx_len_q != '0)) begin
                    bit_cnt_q <= rx_len_q - 1'b1;
                end
            end
            if ((state_q == S_DONE) && (rx_len_q != '0)) begin
                o_data_q <= rx_sr_q;
            end
        end
    end

    assign o_data      = o_data_q;
    assign bit_counter = bit_cnt_q;

endmodule
